// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, mid-bit sampling via BPS_CLK, LSB-first assembly, stop check.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx_ctrl #(
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2,
   parameter int PARITY_ODD  = 0
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 RX_Pin_In,
   input  logic                 Rx_En_Sig,
   input  logic                 BPS_CLK,
   output logic                 Count_Sig,
   output logic [DATA_BITS-1:0] Rx_Data,
   output logic                 Rx_Done_Sig,
   output logic                 Frame_Err_Sig,
   output logic                 Parity_Err_Sig
);

   localparam int CW = $clog2(DATA_BITS) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_DONE
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_rx_d;
   logic                   w_rx_s;
   logic                   w_fall;
   logic                   w_run;
   logic                   r_count;
   logic                   r_done;
   logic                   r_ferr;
   logic [DATA_BITS-1:0]   r_data;
   logic [DATA_BITS-1:0]   r_shift;
   logic [CW-1:0]          r_bit_cnt;

   assign w_rx_s = r_sync[SYNC_STAGES-1];
   assign w_fall = r_rx_d & ~w_rx_s;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_sync <= '1;
         r_rx_d <= 1'b1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], RX_Pin_In};
         r_rx_d <= w_rx_s;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_fall && Rx_En_Sig) w_next = S_START;
         S_START: if (BPS_CLK) w_next = w_rx_s ? S_IDLE : S_DATA;
         S_DATA: begin
            if (BPS_CLK && (r_bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
               w_next = S_PARITY;
`else
               w_next = S_STOP;
`endif
            end
         end
         S_PARITY: if (BPS_CLK) w_next = S_STOP;
         S_STOP:   if (BPS_CLK) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   assign w_run = (w_next == S_START) || (w_next == S_DATA) ||
                  (w_next == S_PARITY) || (w_next == S_STOP);

`ifdef UART_RX_PARITY_EN
   logic r_par_bit;
   logic r_perr;
   logic w_par_err;
   assign w_par_err = ((^r_shift) ^ r_par_bit) != 1'(PARITY_ODD);

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_par_bit <= 1'b0;
         r_perr    <= 1'b0;
      end else begin
         if ((r_state == S_PARITY) && BPS_CLK) r_par_bit <= w_rx_s;
         if ((r_state == S_STOP) && BPS_CLK)   r_perr    <= w_par_err;
      end
   end

   assign Parity_Err_Sig = r_perr;
`else
   logic w_unused_par_sense;
   assign w_unused_par_sense = (PARITY_ODD != 0);
   assign Parity_Err_Sig     = 1'b0;
`endif

   // Results load on the STOP sample so they are already valid during the DONE cycle.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_count   <= 1'b0;
         r_done    <= 1'b0;
         r_ferr    <= 1'b0;
         r_data    <= '0;
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else begin
         r_count <= w_run;
         r_done  <= (w_next == S_DONE);
         case (r_state)
            S_START: if (BPS_CLK && !w_rx_s) r_bit_cnt <= '0;
            S_DATA: begin
               if (BPS_CLK) begin
                  r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                  r_bit_cnt <= r_bit_cnt + CW'(1);
               end
            end
            S_STOP: begin
               if (BPS_CLK) begin
                  r_data <= r_shift;
                  r_ferr <= ~w_rx_s;
               end
            end
            default: ;
         endcase
      end
   end

   assign Count_Sig     = r_count;
   assign Rx_Done_Sig   = r_done;
   assign Rx_Data       = r_data;
   assign Frame_Err_Sig = r_ferr;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural baud-tick generator.
// Bit period is scaled down (64 CLK/bit, first tick 32 CLK after Count_Sig rises).
module tb_uart_rx_ctrl;

   localparam int BIT  = 64;
   localparam int HALF = 32;

   logic       CLK;
   logic       RSTn;
   logic       RX_Pin_In;
   logic       Rx_En_Sig;
   logic       BPS_CLK;
   logic       Count_Sig;
   logic [7:0] Rx_Data;
   logic       Rx_Done_Sig;
   logic       Frame_Err_Sig;
   logic       Parity_Err_Sig;

   int checks   = 0;
   int failures = 0;

   logic [7:0] q_data[$];
   logic       q_ferr[$];
   logic       q_perr[$];
   logic       q_cnt[$];

   uart_rx_ctrl dut (
      .CLK            (CLK),
      .RSTn           (RSTn),
      .RX_Pin_In      (RX_Pin_In),
      .Rx_En_Sig      (Rx_En_Sig),
      .BPS_CLK        (BPS_CLK),
      .Count_Sig      (Count_Sig),
      .Rx_Data        (Rx_Data),
      .Rx_Done_Sig    (Rx_Done_Sig),
      .Frame_Err_Sig  (Frame_Err_Sig),
      .Parity_Err_Sig (Parity_Err_Sig)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Baud-tick generator model: cleared while Count_Sig is low.
   initial begin
      int cnt;
      cnt     = 0;
      BPS_CLK = 1'b0;
      forever begin
         @(negedge CLK);
         if (!Count_Sig) begin
            cnt     = 0;
            BPS_CLK = 1'b0;
         end else begin
            cnt++;
            BPS_CLK = (cnt == HALF) || ((cnt > HALF) && (((cnt - HALF) % BIT) == 0));
         end
      end
   end

   // Records every cycle Rx_Done_Sig is high together with the outputs that accompany it.
   initial begin
      forever begin
         @(negedge CLK);
         if (Rx_Done_Sig === 1'b1) begin
            q_data.push_back(Rx_Data);
            q_ferr.push_back(Frame_Err_Sig);
            q_perr.push_back(Parity_Err_Sig);
            q_cnt.push_back(Count_Sig);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic send_bit(input logic b);
      RX_Pin_In = b;
      repeat (BIT) @(negedge CLK);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
      RX_Pin_In = 1'b1;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_frame_p(input logic [7:0] d, input logic par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(par);
      send_bit(stop);
      RX_Pin_In = 1'b1;
   endtask
`endif

   task automatic test_reset;
      int bad;
      bad       = 0;
      RSTn      = 1'b0;
      RX_Pin_In = 1'b1;
      Rx_En_Sig = 1'b1;
      idle(5);
      RSTn = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge CLK);
         if (Count_Sig !== 1'b0 || Rx_Done_Sig !== 1'b0 ||
             Frame_Err_Sig !== 1'b0 || Parity_Err_Sig !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL reset_idle_outputs nonzero_cycles=%0d expected=0", bad);
      end
      checks++;
      if (Rx_Data !== 8'h00) begin
         failures++;
         $display("FAIL reset_rx_data got=%02h expected=00", Rx_Data);
      end
      checks++;
      if (q_data.size() !== 0) begin
         failures++;
         $display("FAIL reset_no_done got=%0d expected=0", q_data.size());
      end
   endtask

   task automatic test_basic;
      int base;
      base = q_data.size();
      send_frame(8'hA5, 1'b1);
      idle(20);
      checks++;
      if (q_data.size() !== base + 1) begin
         failures++;
         $display("FAIL basic_done_count got=%0d expected=%0d", q_data.size() - base, 1);
      end else begin
         checks++;
         if (q_data[base] !== 8'hA5) begin
            failures++;
            $display("FAIL basic_data got=%02h expected=A5", q_data[base]);
         end
         checks++;
         if (q_ferr[base] !== 1'b0) begin
            failures++;
            $display("FAIL basic_frame_err got=%0b expected=0", q_ferr[base]);
         end
         checks++;
         if (q_cnt[base] !== 1'b0) begin
            failures++;
            $display("FAIL basic_count_in_done got=%0b expected=0", q_cnt[base]);
         end
      end
      checks++;
      if (Rx_Data !== 8'hA5 || Count_Sig !== 1'b0) begin
         failures++;
         $display("FAIL basic_hold data=%02h count=%0b expected data=A5 count=0", Rx_Data, Count_Sig);
      end
   endtask

   task automatic test_glitch;
      int base;
      int saw_high;
      base      = q_data.size();
      saw_high  = 0;
      RX_Pin_In = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         if (Count_Sig === 1'b1) saw_high = 1;
      end
      RX_Pin_In = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         if (Count_Sig === 1'b1) saw_high = 1;
      end
      checks++;
      if (saw_high !== 1) begin
         failures++;
         $display("FAIL glitch_count_rose got=%0d expected=1", saw_high);
      end
      checks++;
      if (Count_Sig !== 1'b0) begin
         failures++;
         $display("FAIL glitch_count_fell got=%0b expected=0", Count_Sig);
      end
      checks++;
      if (q_data.size() !== base || Rx_Data !== 8'hA5) begin
         failures++;
         $display("FAIL glitch_no_done dones=%0d data=%02h expected dones=0 data=A5",
                  q_data.size() - base, Rx_Data);
      end
   endtask

   task automatic test_frame_err;
      int base;
      base = q_data.size();
      send_frame(8'h3C, 1'b0);
      idle(30);
      send_frame(8'h01, 1'b1);
      idle(20);
      checks++;
      if (q_data.size() !== base + 2) begin
         failures++;
         $display("FAIL ferr_done_count got=%0d expected=2", q_data.size() - base);
      end else begin
         checks++;
         if (q_data[base] !== 8'h3C || q_ferr[base] !== 1'b1) begin
            failures++;
            $display("FAIL ferr_bad_stop data=%02h ferr=%0b expected data=3C ferr=1",
                     q_data[base], q_ferr[base]);
         end
         checks++;
         if (q_data[base+1] !== 8'h01 || q_ferr[base+1] !== 1'b0) begin
            failures++;
            $display("FAIL ferr_clean_after data=%02h ferr=%0b expected data=01 ferr=0",
                     q_data[base+1], q_ferr[base+1]);
         end
      end
   endtask

   task automatic test_back_to_back;
      int         base;
      int         saw_high;
      logic [7:0] exp_d[3];
      exp_d = '{8'h55, 8'hFF, 8'h00};
      base  = q_data.size();
      send_frame(8'h55, 1'b1);
      fork
         send_frame(8'hFF, 1'b1);
         begin
            idle(4 * BIT);
            Rx_En_Sig = 1'b0;
            idle(3 * BIT);
            Rx_En_Sig = 1'b1;
         end
      join
      send_frame(8'h00, 1'b1);
      idle(20);
      checks++;
      if (q_data.size() !== base + 3) begin
         failures++;
         $display("FAIL b2b_done_count got=%0d expected=3", q_data.size() - base);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (q_data[base+i] !== exp_d[i] || q_ferr[base+i] !== 1'b0) begin
               failures++;
               $display("FAIL b2b_frame%0d data=%02h ferr=%0b expected data=%02h ferr=0",
                        i, q_data[base+i], q_ferr[base+i], exp_d[i]);
            end
         end
      end
      Rx_En_Sig = 1'b0;
      idle(10);
      base     = q_data.size();
      saw_high = 0;
      fork
         send_frame(8'h5A, 1'b1);
         for (int i = 0; i < 10 * BIT; i++) begin
            @(negedge CLK);
            if (Count_Sig === 1'b1) saw_high = 1;
         end
      join
      idle(20);
      checks++;
      if (saw_high !== 0 || q_data.size() !== base || Rx_Data !== 8'h00) begin
         failures++;
         $display("FAIL disabled_ignored count_rose=%0d dones=%0d data=%02h expected 0 0 00",
                  saw_high, q_data.size() - base, Rx_Data);
      end
      Rx_En_Sig = 1'b1;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity;
      int base;
      base = q_data.size();
      send_frame_p(8'h07, 1'b1, 1'b1);
      idle(30);
      send_frame_p(8'h07, 1'b0, 1'b1);
      idle(20);
      checks++;
      if (q_data.size() !== base + 2) begin
         failures++;
         $display("FAIL parity_done_count got=%0d expected=2", q_data.size() - base);
      end else begin
         checks++;
         if (q_data[base] !== 8'h07 || q_perr[base] !== 1'b0) begin
            failures++;
            $display("FAIL parity_good data=%02h perr=%0b expected data=07 perr=0",
                     q_data[base], q_perr[base]);
         end
         checks++;
         if (q_perr[base+1] !== 1'b1) begin
            failures++;
            $display("FAIL parity_bad perr=%0b expected=1", q_perr[base+1]);
         end
      end
   endtask
`endif

   task automatic test_reset_mid;
      int base;
      send_frame(8'h3C, 1'b0);
      idle(30);
      base = q_data.size();
      fork
         send_frame(8'h99, 1'b1);
         begin
            idle(3 * BIT);
            checks++;
            if (Count_Sig !== 1'b1) begin
               failures++;
               $display("FAIL rstmid_running got=%0b expected=1", Count_Sig);
            end
            RSTn = 1'b0;
            #1;
            checks++;
            if (Count_Sig !== 1'b0 || Rx_Done_Sig !== 1'b0) begin
               failures++;
               $display("FAIL rstmid_async count=%0b done=%0b expected 0 0", Count_Sig, Rx_Done_Sig);
            end
            checks++;
            if (Rx_Data !== 8'h00 || Frame_Err_Sig !== 1'b0 || Parity_Err_Sig !== 1'b0) begin
               failures++;
               $display("FAIL rstmid_values data=%02h ferr=%0b perr=%0b expected 00 0 0",
                        Rx_Data, Frame_Err_Sig, Parity_Err_Sig);
            end
         end
      join
      idle(20);
      RSTn = 1'b1;
      idle(20);
      send_frame(8'hC3, 1'b1);
      idle(20);
      checks++;
      if (q_data.size() !== base + 1 || Rx_Data !== 8'hC3 || Frame_Err_Sig !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_recover dones=%0d data=%02h ferr=%0b expected 1 C3 0",
                  q_data.size() - base, Rx_Data, Frame_Err_Sig);
      end
   endtask

   initial begin
      RSTn      = 1'b0;
      RX_Pin_In = 1'b1;
      Rx_En_Sig = 1'b1;
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_back_to_back();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
